// File: rtl/mul_div_if.sv
// Request/response bundle between the CPU control and the RV32M execute unit.
interface mul_div_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            wr_en;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd_in,
        input  busy, done, result, rd_out, wr_en
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd_in,
        output busy, done, result, rd_out, wr_en
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiplier and restoring divider sharing
// one accumulator/shift register pair. Fixed latency of XLEN+1 edges after acceptance.
module mul_div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_div_if.slave   bus
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    // acc: product high half / partial remainder; lo: multiplier / dividend-quotient.
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    // b: multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [XLEN-1:0] b_q, b_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic            b_zero_q, b_zero_d;
    logic            ovf_q, ovf_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic            done_q, done_d;

    // Operand decode for the incoming request.
    logic            a_signed, b_signed;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_signed = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
    assign b_signed = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign a_mag = (a_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
    assign b_mag = (b_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;

    // Multiply step: conditionally add multiplicand, then shift {acc, lo} right.
    logic [XLEN:0] mul_sum, mul_hi;
    assign mul_sum = {1'b0, acc_q} + {1'b0, b_q};
    assign mul_hi  = lo_q[0] ? mul_sum : {1'b0, acc_q};

    // Divide step: shift in next dividend bit, subtract divisor if it fits.
    logic [XLEN:0]   div_trial;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;
    assign div_trial = {acc_q, lo_q[XLEN-1]};
    assign div_ge    = div_trial >= {1'b0, b_q};
    // The true difference is below the divisor, so the low XLEN bits are exact.
    assign div_sub   = div_trial[XLEN-1:0] - b_q;

    // Sign correction of the finished magnitudes.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -{acc_q, lo_q} : {acc_q, lo_q};
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    assign rem_fix  = neg_a_q ? -acc_q : acc_q;

    // Final result selection including divide-by-zero and signed-overflow overrides.
    logic [XLEN-1:0] fin_val;
    always_comb begin
        fin_val = '0;
        unique case (op_q)
            3'b000:                 fin_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (b_zero_q)   fin_val = '1;
                else if (ovf_q) fin_val = MinNeg;
                else            fin_val = quo_fix;
            end
            3'b110, 3'b111: begin
                if (b_zero_q)   fin_val = rs1_q;
                else if (ovf_q) fin_val = '0;
                else            fin_val = rem_fix;
            end
            default:                fin_val = '0;
        endcase
    end

    // Next-state and datapath update for the IDLE/CALC/FIN sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        ovf_d    = ovf_q;
        rs1_d    = rs1_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    op_d     = bus.funct3;
                    rd_d     = bus.rd_in;
                    acc_d    = '0;
                    lo_d     = bus.funct3[2] ? a_mag : b_mag;
                    b_d      = bus.funct3[2] ? b_mag : a_mag;
                    neg_a_d  = a_signed && bus.rs1_val[XLEN-1];
                    neg_b_d  = b_signed && bus.rs2_val[XLEN-1];
                    b_zero_d = (bus.rs2_val == '0);
                    ovf_d    = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                               (bus.rs1_val == MinNeg) && (bus.rs2_val == '1);
                    rs1_d    = bus.rs1_val;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CntW'(1);
                if (op_q[2]) begin
                    acc_d = div_ge ? div_sub : div_trial[XLEN-1:0];
                    lo_d  = {lo_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = mul_hi[XLEN:1];
                    lo_d  = {mul_hi[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CntLast) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                result_d = fin_val;
                rd_out_d = rd_q;
                done_d   = 1'b1;
                cnt_d    = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            ovf_q    <= 1'b0;
            rs1_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            ovf_q    <= ovf_d;
            rs1_q    <= rs1_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
    assign bus.wr_en  = done_q && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized bench for mul_div_unit with a result scoreboard.
module tb_mul_div_unit;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_div_if #(.XLEN(XLEN)) bus ();

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_res[$];
    logic [4:0]  exp_rd[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference behaviour built from plain SV arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ub = $signed({32'b0, b});
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        bus.start   = 1'b1;
        exp_res.push_back(exp);
        exp_rd.push_back(rd);
        tick();
        bus.start   = 1'b0;
    endtask

    // Waits for done; optionally pokes a conflicting start after edge 'poke'.
    task automatic wait_done(input int poke, output int lat, output logic busy_ok);
        logic got;
        got = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40 && !got; n++) begin
            tick();
            if (n == poke) begin
                bus.start   = 1'b1;
                bus.funct3  = 3'b000;
                bus.rs1_val = 32'h1234;
                bus.rs2_val = 32'h5;
                bus.rd_in   = 5'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                got = 1'b1;
                lat = n;
            end else if (n <= 32 && bus.busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic finish_op(input string tag, input int lat, input logic busy_ok);
        logic [31:0] er;
        logic [4:0]  ed;
        er = 32'hDEAD_BEEF;
        ed = 5'd0;
        if (exp_res.size() > 0) begin
            er = exp_res.pop_front();
            ed = exp_rd.pop_front();
        end
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
        check({tag, "_busy_done"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_result"}, bus.result, er);
        check({tag, "_rd_out"}, {27'b0, bus.rd_out}, {27'b0, ed});
        check({tag, "_wr_en"}, {31'b0, bus.wr_en}, {31'b0, (ed != 5'd0)});
    endtask

    task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int lat;
        logic ok;
        issue(f3, a, b, rd, exp);
        wait_done(0, lat, ok);
        finish_op(tag, lat, ok);
    endtask

    initial begin
        int lat;
        logic ok;
        int dones;
        logic [2:0] f3;
        logic [31:0] a, b;

        bus.start = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_in = '0;

        // Reset state
        #12;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd_out", {27'b0, bus.rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // MUL with done-pulse width check
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        wait_done(0, lat, ok);
        finish_op("mul", lat, ok);
        tick();
        check("mul_done_pulse", {31'b0, bus.done}, 32'd0);
        check("mul_wr_pulse", {31'b0, bus.wr_en}, 32'd0);
        check("mul_result_hold", bus.result, 32'hFFFF_FFEB);

        run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF);
        run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
        run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
        run("divu", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14);
        run("remu", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2);
        run("divu_zero", 3'b101, 32'd100, 32'd0, 5'd10, 32'hFFFF_FFFF);
        run("rem_zero", 3'b110, 32'd100, 32'd0, 5'd11, 32'd100);
        run("div_zero_neg", 3'b100, 32'hFFFF_FFF9, 32'd0, 5'd12, 32'hFFFF_FFFF);
        run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
        run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0);

        // Start during busy is ignored; inputs changed after acceptance do not matter
        issue(3'b101, 32'd1000, 32'd3, 5'd15, 32'd333);
        wait_done(5, lat, ok);
        finish_op("ignore_start", lat, ok);
        // Back-to-back: start in the done cycle, with rd=0 (no write strobe)
        issue(3'b000, 32'd6, 32'd9, 5'd0, 32'd54);
        wait_done(0, lat, ok);
        finish_op("b2b_rd0", lat, ok);
        check("b2b_rd0_done", {31'b0, bus.done}, 32'd1);

        // Randomized ops against the reference model
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) b = b & 32'h0000_00FF;
            run("rand", f3, a, b, 5'(i + 16), ref_model(f3, a, b));
        end

        // Reset mid-operation
        issue(3'b100, 32'd12345, 32'd7, 5'd21, 32'd1763);
        for (int n = 1; n < 10; n++) tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_rd_out", {27'b0, bus.rd_out}, 32'd0);
        exp_res.delete();
        exp_rd.delete();
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.done !== 1'b0) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);

        run("post_reset", 3'b111, 32'd55, 32'd10, 5'd3, 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
